// File: rtl/clkrstgen.sv
`default_nettype none
// ============================================================================
// Module      : clkrstgen
// Description : Board clock divider, button debouncer and power-on reset
//               sequencer. The divided clock "clk" is produced as a register
//               in the CLK domain, and clk_rise marks its rising edges.
//               power_on_reset is held until the debounced button has been
//               released. It then stays held for PORCYCLES clk periods and
//               deasserts only on a clk falling edge.
// Ports       : CLK            - board clock, sole clock of the block
//               RST_N          - asynchronous active-low reset
//               BTN_N          - raw bouncy button, active-low
//               div_sel        - half-period select, divisor = 2*(div_sel+1)
//               clk            - divided clock, 50% duty, registered
//               clk_rise       - one-CLK pulse while clk enters its high phase
//               power_on_reset - active-high system reset
//               btn_state      - debounced button, 1 = pressed
// Revision    : 1.0 - initial release
// ============================================================================
module clkrstgen #(
    parameter int DIVBITS   = 4,
    parameter int DEBOUNCE  = 1024,
    parameter int PORCYCLES = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               BTN_N,
    input  logic [DIVBITS-1:0] div_sel,
    output logic               clk,
    output logic               clk_rise,
    output logic               power_on_reset,
    output logic               btn_state
);

    localparam int DBW = $clog2(DEBOUNCE);
    localparam int PCW = $clog2(PORCYCLES + 1);

    localparam logic [DBW-1:0] c_DEB_LAST = DBW'(DEBOUNCE - 1);
    localparam logic [PCW-1:0] c_POR_DONE = PCW'(PORCYCLES);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_COUNT = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Clock divider
    // ------------------------------------------------------------------
    logic [DIVBITS-1:0] r_hcnt;
    logic [DIVBITS-1:0] r_hsel;
    logic               w_half_done;
    logic               w_fall;

    assign w_half_done = (r_hcnt == r_hsel);
    // clk is about to go 1->0 on this edge: the end of a full period.
    assign w_fall      = w_half_done & clk;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hcnt   <= '0;
            r_hsel   <= DIVBITS'(1);
            clk      <= 1'b0;
            clk_rise <= 1'b0;
        end else begin
            // Registered together with clk so that the pulse covers exactly
            // the first CLK cycle of the high phase.
            clk_rise <= w_half_done & ~clk;
            if (w_half_done) begin
                r_hcnt <= '0;
                clk    <= ~clk;
                // div_sel is loaded only at the end of a full period. A change
                // made in mid-period can therefore never shorten a phase.
                if (clk) begin
                    r_hsel <= div_sel;
                end
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Button synchroniser and debouncer
    // ------------------------------------------------------------------
    logic [1:0]     r_sync;
    logic [DBW-1:0] r_dcnt;
    logic           w_btn_pressed;

    assign w_btn_pressed = ~r_sync[1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync    <= 2'b11;         // released level of an active-low button
            r_dcnt    <= '0;
            btn_state <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], BTN_N};
            if (w_btn_pressed == btn_state) begin
                r_dcnt <= '0;
            end else if (r_dcnt == c_DEB_LAST) begin
                btn_state <= w_btn_pressed;
                r_dcnt    <= '0;
            end else begin
                r_dcnt <= r_dcnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reset sequencer
    // ------------------------------------------------------------------
    state_t         r_state;
    logic [PCW-1:0] r_porcnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state        <= ST_HOLD;
            r_porcnt       <= '0;
            power_on_reset <= 1'b1;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    power_on_reset <= 1'b1;
                    r_porcnt       <= '0;
                    if (!btn_state) begin
                        r_state <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (btn_state) begin
                        r_state  <= ST_HOLD;
                        r_porcnt <= '0;
                    end else if (w_fall && (r_porcnt == c_POR_DONE)) begin
                        // Release only where clk falls, so logic clocked by
                        // clk sees a full low phase before its first edge.
                        r_state        <= ST_RUN;
                        power_on_reset <= 1'b0;
                    end else if (clk_rise && (r_porcnt != c_POR_DONE)) begin
                        r_porcnt <= r_porcnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (btn_state) begin
                        r_state        <= ST_HOLD;
                        r_porcnt       <= '0;
                        power_on_reset <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= ST_HOLD;
                    r_porcnt       <= '0;
                    power_on_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clkrstgen.sv
`default_nettype none
// ============================================================================
// Module      : tb_clkrstgen
// Description : Directed self-checking bench for clkrstgen. The main instance
//               uses the default parameters. A second instance with a short
//               debounce window exercises button release/re-press during the
//               reset count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clkrstgen;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       BTN_N;
    logic       btn_n_f;
    logic [3:0] div_sel;

    logic clk_o, clk_rise, por, btn_state;
    logic clk_f, clk_rise_f, por_f, btn_state_f;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    string       tag_q[$];
    logic [31:0] val_q[$];

    clkrstgen u_dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .BTN_N          (BTN_N),
        .div_sel        (div_sel),
        .clk            (clk_o),
        .clk_rise       (clk_rise),
        .power_on_reset (por),
        .btn_state      (btn_state)
    );

    clkrstgen #(
        .DIVBITS   (4),
        .DEBOUNCE  (4),
        .PORCYCLES (16)
    ) u_dut_fast (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .BTN_N          (btn_n_f),
        .div_sel        (div_sel),
        .clk            (clk_f),
        .clk_rise       (clk_rise_f),
        .power_on_reset (por_f),
        .btn_state      (btn_state_f)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    task automatic expect_val(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        val_q.push_back(val);
    endtask

    task automatic check(input logic [31:0] obs);
        string       tag;
        logic [31:0] val;
        n_checks++;
        if (tag_q.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=queued_value", obs);
            return;
        end
        tag = tag_q.pop_front();
        val = val_q.pop_front();
        assert (obs === val) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, val);
        end
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        n_errors++;
        $error("FAIL timeout_%s observed=expired expected=event", tag);
    endtask

    // Waits until main clk is sampled at lvl after being sampled at ~lvl.
    task automatic wait_edge(input logic lvl, output int t);
        logic prev;
        prev = clk_o;
        t    = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (clk_o === lvl && prev !== lvl) begin
                t = cyc;
                break;
            end
            prev = clk_o;
        end
        if (t < 0) timeout("clk_edge");
    endtask

    // Called at a falling-edge sample; measures the following full period.
    task automatic measure_period(output int per, output int hi, output int rises);
        logic prev;
        prev  = clk_o;
        per   = 0;
        hi    = 0;
        rises = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            per++;
            if (clk_o) hi++;
            if (clk_rise) rises++;
            if (!clk_o && prev) return;
            prev = clk_o;
        end
        timeout("period");
    endtask

    // Follows the main instance from reset release until power_on_reset drops.
    task automatic por_run(input string tag, input int t0);
        int   t;
        int   rises;
        logic prev;
        expect_val({tag, "_rises"}, 16);
        expect_val({tag, "_time_near_68"}, 1);
        expect_val({tag, "_clk_low_at_release"}, 0);
        expect_val({tag, "_clk_was_high"}, 1);
        t     = -1;
        rises = 0;
        prev  = clk_o;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (clk_rise) rises++;
            if (!por) begin
                t = cyc;
                break;
            end
            prev = clk_o;
        end
        if (t < 0) timeout(tag);
        check(rises);
        check(((t - t0) >= 60 && (t - t0) <= 72) ? 1 : 0);
        check(clk_o);
        check(prev);
    endtask

    int t0, t1, t2, tl, tp;
    int per, hi, rises;
    int got;
    int por_bad;
    logic prevc;

    initial begin
        // ---------------- reset state ----------------
        RST_N   = 1'b0;
        BTN_N   = 1'b1;
        btn_n_f = 1'b1;
        div_sel = 4'd1;
        expect_val("rst_clk", 0);
        expect_val("rst_clk_rise", 0);
        expect_val("rst_por", 1);
        expect_val("rst_btn_state", 0);
        expect_val("rst_por_fast", 1);
        repeat (5) @(negedge CLK);
        check(clk_o);
        check(clk_rise);
        check(por);
        check(btn_state);
        check(por_f);

        // ---------------- POR sequence, div_sel = 1 ----------------
        RST_N = 1'b1;
        t0    = cyc;
        por_run("por1", t0);

        // ---------------- div_sel change mid high phase ----------------
        expect_val("chg_cur_period", 4);
        expect_val("chg_next_period", 8);
        expect_val("chg_next_high", 4);
        expect_val("chg_next_rises", 1);
        wait_edge(1'b0, t1);
        wait_edge(1'b1, t2);
        div_sel = 4'd3;
        wait_edge(1'b0, t2);
        check(t2 - t1);
        measure_period(per, hi, rises);
        check(per);
        check(hi);
        check(rises);

        // ---------------- divider extremes ----------------
        expect_val("div15_period", 32);
        expect_val("div15_high", 16);
        expect_val("div15_rises", 1);
        div_sel = 4'd15;
        wait_edge(1'b0, t1);
        measure_period(per, hi, rises);
        check(per);
        check(hi);
        check(rises);

        expect_val("div0_period", 2);
        expect_val("div0_high", 1);
        expect_val("div0_rises", 1);
        div_sel = 4'd0;
        wait_edge(1'b0, t1);
        measure_period(per, hi, rises);
        check(per);
        check(hi);
        check(rises);

        // ---------------- async reset in RUN with clk high ----------------
        div_sel = 4'd1;
        wait_edge(1'b0, t1);
        wait_edge(1'b1, t1);
        expect_val("async_clk_high_before", 1);
        expect_val("async_clk", 0);
        expect_val("async_clk_rise", 0);
        expect_val("async_por", 1);
        check(clk_o);
        #2 RST_N = 1'b0;
        #1;
        check(clk_o);
        check(clk_rise);
        check(por);
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        t0    = cyc;
        por_run("por2", t0);

        // ---------------- first period after reset uses divide-by-4 ----------------
        expect_val("first_fall_after_release", 4);
        expect_val("period_after_load", 8);
        div_sel = 4'd3;
        RST_N   = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        t0    = cyc;
        wait_edge(1'b0, t1);
        check(t1 - t0);
        measure_period(per, hi, rises);
        check(per);

        // ---------------- debounce of a bouncy press ----------------
        expect_val("run_before_bounce", 0);
        got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (!por) begin
                got = 1;
                break;
            end
        end
        if (got == 0) timeout("run_before_bounce");
        check(por);

        expect_val("bounce_rejected", 0);
        expect_val("debounce_latency_1026pm2", 1);
        expect_val("por_still_low_at_accept", 0);
        expect_val("por_after_accept", 1);
        expect_val("btn_stays_pressed", 0);
        for (int i = 0; i < 11; i++) begin
            BTN_N = ~BTN_N;
            tl    = cyc;
            repeat (45) @(negedge CLK);
        end
        check(btn_state);
        t1 = -1;
        for (int i = 0; i < 1200; i++) begin
            @(negedge CLK);
            if (btn_state) begin
                t1 = cyc;
                break;
            end
        end
        if (t1 < 0) timeout("debounce");
        check(((t1 - tl) >= 1024 && (t1 - tl) <= 1028) ? 1 : 0);
        check(por);
        @(negedge CLK);
        check(por);
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (!btn_state) got = 1;
        end
        check(got);

        // ---------------- release / re-press during COUNT (short debounce) ----------------
        div_sel = 4'd1;
        wait_edge(1'b0, t1);
        wait_edge(1'b0, t1);
        expect_val("fast_in_run", 0);
        expect_val("fast_press_latency", 6);
        expect_val("fast_por_after_press", 1);
        check(por_f);
        btn_n_f = 1'b0;
        tp      = cyc;
        t1      = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (btn_state_f) begin
                t1 = cyc;
                break;
            end
        end
        if (t1 < 0) timeout("fast_press");
        check(t1 - tp);
        @(negedge CLK);
        check(por_f);

        expect_val("fast_repress_seen", 1);
        expect_val("fast_por_held_in_count", 0);
        expect_val("fast_por_in_hold", 1);
        btn_n_f = 1'b1;
        got     = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (!btn_state_f) begin
                got = 1;
                break;
            end
        end
        if (got == 0) timeout("fast_release1");
        rises   = 0;
        por_bad = 0;
        got     = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (clk_rise_f) rises++;
            if (!por_f) por_bad = 1;
            if (rises == 8 && btn_n_f) btn_n_f = 1'b0;
            if (btn_state_f) begin
                got = 1;
                break;
            end
        end
        check(got);
        check(por_bad);
        @(negedge CLK);
        check(por_f);

        // A cleared counter means a full 16 clk_rise pulses after this release.
        expect_val("fast_restart_rises", 16);
        expect_val("fast_release_on_fall_low", 0);
        expect_val("fast_release_on_fall_was_high", 1);
        btn_n_f = 1'b1;
        got     = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (!btn_state_f) begin
                got = 1;
                break;
            end
        end
        if (got == 0) timeout("fast_release2");
        rises = 0;
        prevc = clk_f;
        got   = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (clk_rise_f) rises++;
            if (!por_f) begin
                got = 1;
                break;
            end
            prevc = clk_f;
        end
        if (got == 0) timeout("fast_por_release");
        check(rises);
        check(clk_f);
        check(prevc);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
